// File: rtl/shift_register_sequencer.sv
// Command sequencer for an 8-bit universal shift register.
// Accepts one command per start/busy/done handshake: an optional parallel
// load, then `count` shift or rotate cycles. Vectors use [0:WIDTH-1] so
// index 0 is the register MSB (Q0/P0). This keeps hex literals readable:
// 8'hA5 puts a 1 on P0.
module shift_register_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             load_first,
  input  logic             dir,
  input  logic             rotate,
  input  logic             fill,
  input  logic [CNT_W-1:0] count,
  input  logic [0:WIDTH-1] data,
  input  logic [0:WIDTH-1] q,
  output logic             s0,
  output logic             s1,
  output logic             SR,
  output logic             SL,
  output logic [0:WIDTH-1] P,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             dir_r;
  logic             rot_r;
  logic             fill_r;

  // Rotate feedback uses only the two end bits; the interior bits are ignored.
  logic unused_q;
  assign unused_q = ^q[1:WIDTH-2];

  // Control FSM. The mode pins, P, busy and done are registered. Each
  // transition loads the outputs that belong to the state being entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_r  <= 1'b0;
      rot_r  <= 1'b0;
      fill_r <= 1'b0;
      s0     <= 1'b0;
      s1     <= 1'b0;
      P      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      P    <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            cnt    <= count;
            dir_r  <= dir;
            rot_r  <= rotate;
            fill_r <= fill;
            busy   <= 1'b1;
            if (load_first) begin
              state <= LOAD;
              s0    <= 1'b1;
              s1    <= 1'b1;
              P     <= data;
            end else if (count != '0) begin
              state <= SHIFT;
              s0    <= ~dir;
              s1    <= dir;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (cnt != '0) begin
            state <= SHIFT;
            s0    <= ~dir_r;
            s1    <= dir_r;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            s0 <= ~dir_r;
            s1 <= dir_r;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial inputs come straight from q. Each shift edge therefore sees the
  // value left by the previous edge. Both are 0 outside SHIFT.
  always_comb begin
    SR = 1'b0;
    SL = 1'b0;
    if (state == SHIFT) begin
      if (!dir_r) SR = rot_r ? q[WIDTH-1] : fill_r;
      else        SL = rot_r ? q[0]       : fill_r;
    end
  end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Scoreboard bench for shift_register_sequencer. A model of the universal
// shift register closes the q loop. Expected results come from an integer
// reference model and are checked by an independent monitor.
module tb_shift_register_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, load_first = 1'b0, dir = 1'b0, rotate = 1'b0, fill = 1'b0;
  logic [CW-1:0] count = '0;
  logic [0:W-1]  data = '0;
  logic [0:W-1]  q;
  logic          s0, s1, SR, SL, busy, done;
  logic [0:W-1]  P;

  // The register has no reset and powers up all ones.
  logic [0:W-1]  reg_q = 8'hFF;
  assign q = reg_q;

  always #5 clock = ~clock;

  shift_register_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .load_first(load_first),
    .dir(dir), .rotate(rotate), .fill(fill), .count(count), .data(data),
    .q(q), .s0(s0), .s1(s1), .SR(SR), .SL(SL), .P(P), .busy(busy), .done(done)
  );

  // Universal shift register: 11 load, 10 right (SR enters Q0), 01 left (SL enters Q7).
  always @(posedge clock) begin
    case ({s0, s1})
      2'b11:   reg_q <= P;
      2'b10:   reg_q <= {SR, reg_q[0:W-2]};
      2'b01:   reg_q <= {reg_q[1:W-1], SL};
      default: reg_q <= reg_q;
    endcase
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int q;
    int loads;
    int shifts;
    int busy_n;
    int done_at;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   errs = 0, checks = 0;
  int   model_q = 'hFF;
  int   n_load = 0, n_shift = 0, n_busy = 0;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: the final register value as 8-bit hex, MSB = Q0.
  function automatic int ref_run(int v0, bit lf, int d, bit dn, bit rot, bit fl, int n);
    int v;
    int b;
    v = lf ? (d & 255) : v0;
    for (int i = 0; i < n; i++) begin
      if (!dn) begin
        b = rot ? (v & 1) : int'(fl);
        v = (v >> 1) | (b << 7);
      end else begin
        b = rot ? ((v >> 7) & 1) : int'(fl);
        v = ((v << 1) & 255) | b;
      end
    end
    return v;
  endfunction

  // Monitor: counts mode cycles and checks each done against the scoreboard.
  always @(negedge clock) begin
    if (!reset_n) begin
      n_load = 0; n_shift = 0; n_busy = 0;
    end else begin
      if (s0 && s1) n_load++;
      if (s0 ^ s1)  n_shift++;
      if (busy)     n_busy++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e_mon = sb.pop_front();
          chk("done_q",      int'(q), e_mon.q);
          chk("load_cycles", n_load,  e_mon.loads);
          chk("shift_cycles",n_shift, e_mon.shifts);
          chk("busy_cycles", n_busy,  e_mon.busy_n);
          chk("done_cycle",  cyc,     e_mon.done_at);
          chk("done_mode",   int'({s0, s1}), 0);
        end
        n_load = 0; n_shift = 0; n_busy = 0;
      end
    end
  end

  task automatic drive(bit lf, bit dn, bit rot, bit fl, int n, int d);
    load_first = lf; dir = dn; rotate = rot; fill = fl;
    count = CW'(n); data = W'(d);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 100) begin
      @(negedge clock);
      t++;
    end
    chk("idle_timeout", int'(t < 100), 1);
  endtask

  task automatic issue(bit lf, bit dn, bit rot, bit fl, int n, int d);
    exp_t e;
    e.q       = ref_run(model_q, lf, d, dn, rot, fl, n);
    e.loads   = int'(lf);
    e.shifts  = n;
    e.busy_n  = int'(lf) + n + 1;
    e.done_at = cyc + 1 + int'(lf) + n;
    model_q   = e.q;
    sb.push_back(e);
    drive(lf, dn, rot, fl, n, d);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    int v2;
    exp_t e;
    // Reset held: outputs stay 0 while start toggles.
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      load_first = 1'b1;
      @(negedge clock);
      chk("reset_outputs", int'({s0, s1, SR, SL, busy, done, P}), 0);
    end
    chk("reset_q_holds", int'(q), 'hFF);
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    // Directed commands.
    issue(1, 0, 0, 0, 0, 'hA5);          // plain load
    issue(1, 0, 0, 0, 3, 'hA5);          // load then right x3 -> 0x14
    issue(1, 0, 0, 0, 0, 'hA5);
    issue(0, 1, 1, 0, 4, 0);             // rotate left x4 -> 0x5A
    issue(0, 1, 1, 0, 8, 0);             // full rotation leaves 0x5A
    issue(1, 1, 0, 1, 2, 'h81);          // -> 0x07
    issue(1, 1, 0, 0, 12, 'h81);         // -> 0x00
    issue(0, 0, 0, 0, 0, 0);             // no load, no shift

    // A start pulsed during SHIFT must be ignored.
    e.q       = ref_run(model_q, 0, 0, 0, 0, 1, 10);
    e.loads   = 0;
    e.shifts  = 10;
    e.busy_n  = 11;
    e.done_at = cyc + 1 + 10;
    model_q   = e.q;
    sb.push_back(e);
    drive(0, 0, 0, 1, 10, 0);
    repeat (3) @(negedge clock);
    load_first = 1'b1; data = 8'h00; count = CW'(1); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("no_queued_cmd", int'(busy), 0);
    end

    // Reset in the 3rd SHIFT cycle aborts the command.
    issue(1, 0, 0, 0, 0, 'h96);
    v2 = ref_run(model_q, 0, 0, 0, 1, 0, 2);
    drive(0, 0, 1, 0, 6, 0);
    ns = 0;
    for (int t = 0; t < 20; t++) begin
      if (s0 ^ s1) ns++;
      if (ns == 3) break;
      @(negedge clock);
    end
    chk("abort_reached_shift3", ns, 3);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", int'({s0, s1, SR, SL, busy, done, P}), 0);
    chk("abort_q", int'(q), v2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("abort_no_done", int'(done), 0);
    end
    chk("abort_q_held", int'(q), v2);
    reset_n = 1'b1;
    model_q = v2;
    @(negedge clock);
    issue(0, 1, 0, 1, 5, 0);

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
